// File: rtl/servo_pkg.sv
// Shared types and helpers for the servo PWM scheduler: FSM state, pulse-width
// type, range clamp and per-commit slew step.
package servo_pkg;

  typedef enum logic [1:0] {OFF, RUN, DRAIN} state_t;

  typedef logic [10:0] width_t;

  function automatic width_t clamp_width(input width_t w, input width_t lo, input width_t hi);
    if (w < lo) return lo;
    if (w > hi) return hi;
    return w;
  endfunction

  // Differences are only formed once the ordering is known, so nothing wraps.
  function automatic width_t slew_step(input width_t cur, input width_t tgt, input width_t step);
    if (tgt > cur && (tgt - cur) > step) return cur + step;
    if (cur > tgt && (cur - tgt) > step) return cur - step;
    return tgt;
  endfunction

endpackage

// File: rtl/servo_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clocks while run is high;
// held at zero while stopped so a new run always starts on a full tick period.
module servo_tick_gen #(
  parameter int DIV = 100
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

  logic [PW-1:0] pre_q;

  assign tick = run && (pre_q == PW'(DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              pre_q <= '0;
    else if (!run || tick) pre_q <= '0;
    else                   pre_q <= pre_q + PW'(1);
  end

endmodule

// File: rtl/servo_pwm_scheduler.sv
// Multi-channel servo PWM sequencer: shadow widths from the command port are
// committed to the outputs only at frame boundaries. SERVO_SLEW_LIMIT_EN limits
// the per-commit width change to SLEW_US.
module servo_pwm_scheduler
  import servo_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1_000_000,
  parameter int N_CH     = 4,
  parameter int FRAME_US = 20000,
  parameter int MIN_US   = 1000,
  parameter int MAX_US   = 2000,
  parameter int SLEW_US  = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [2:0]      cmd_ch,
  input  logic [10:0]     cmd_width_us,
  output logic            cmd_err,
  output logic            frame_start,
  output logic [N_CH-1:0] pwm_out
);

  localparam int     DIV    = CLK_HZ / TICK_HZ;
  localparam int     UW     = $clog2(FRAME_US);
  localparam int     CMPW   = (UW > 11) ? UW : 11;
  localparam width_t CENTER = width_t'((MIN_US + MAX_US) / 2);
  localparam width_t WMIN   = width_t'(MIN_US);
  localparam width_t WMAX   = width_t'(MAX_US);

  if ((CLK_HZ % TICK_HZ) != 0 || DIV < 2 || N_CH < 1 || N_CH > 8 ||
      MIN_US > MAX_US || MAX_US >= FRAME_US || MAX_US > 2047 ||
      SLEW_US < 1 || SLEW_US > 2047) begin : g_bad_params
    $error("servo_pwm_scheduler: illegal parameter combination");
  end

  state_t        state_q;
  logic [UW-1:0] us_cnt_q;
  logic          frame_start_q;
  logic          cmd_err_q;
  logic          run;
  logic          tick;
  logic          wrap;
  logic          accept;
  logic          ch_ok;
  logic          commit;
  width_t        cmd_w;

  servo_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  assign run    = (state_q != OFF);
  assign wrap   = tick && (us_cnt_q == UW'(FRAME_US - 1));
  assign accept = cmd_valid && cmd_ready;
  assign ch_ok  = int'(cmd_ch) < N_CH;
  assign cmd_w  = clamp_width(cmd_width_us, WMIN, WMAX);
  // Entry to RUN and every frame wrap that continues running both load active.
  assign commit = enable && ((state_q == OFF) || wrap);

  assign cmd_ready   = ~wrap;
  assign cmd_err     = cmd_err_q;
  assign frame_start = frame_start_q;

  // At the wrap, enable alone decides between another frame and stopping, so a
  // drop of enable exactly on the wrap stops cleanly without a further commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= OFF;
      us_cnt_q      <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        OFF: begin
          us_cnt_q <= '0;
          if (enable) begin
            state_q       <= RUN;
            frame_start_q <= 1'b1;
          end
        end
        default: begin
          if (wrap) begin
            us_cnt_q      <= '0;
            state_q       <= enable ? RUN : OFF;
            frame_start_q <= enable;
          end else begin
            if (tick) us_cnt_q <= us_cnt_q + UW'(1);
            state_q <= enable ? RUN : DRAIN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cmd_err_q <= 1'b0;
    else      cmd_err_q <= accept && !ch_ok;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    width_t shadow_q;
    width_t active_q;
    width_t active_d;
    logic   pwm_q;

`ifdef SERVO_SLEW_LIMIT_EN
    assign active_d = slew_step(active_q, shadow_q, width_t'(SLEW_US));
`else
    assign active_d = shadow_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        shadow_q <= CENTER;
        active_q <= CENTER;
        pwm_q    <= 1'b0;
      end else begin
        if (accept && (cmd_ch == 3'(i))) shadow_q <= cmd_w;
        if (commit) active_q <= active_d;
        pwm_q <= run && (CMPW'(us_cnt_q) < CMPW'(active_q));
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule
